ddc_dec_core: RTL and testbench
===============================

Name: ddc_dec_core

Overview:
- Parametrised successor to the single-rate DDC core.
- Mixes complex ADC samples with an externally supplied DDS tone through a width-generic, depth-configurable pipelined complex multiplier.
- Adds a runtime-selectable conjugate mode and an integrate-and-dump decimator with a programmable length.
- Sits between the ADC stream/DDS generator and the per-tone readout FIFO. Output rate drops by dec_len, easing downstream bandwidth.

Parameters:
- ADC_W, 12, ADC sample width per lane (2..16).
- DDS_W, 14, DDS sample width per lane (2..16).
- MUL_STAGES, 5, register stages in each real multiplier (>=1).
- DEC_W, 16, width of dec_len; maximum decimation is 2^DEC_W-1.
- OUT_W, 48, output lane width. Elaboration error unless OUT_W >= ADC_W+DDS_W+1+DEC_W.

Ports:
- s_axis_aclk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  32  ADC sample: I [ADC_W-1:0], Q [ADC_W+15:16], two's complement
- s_axis_tvalid  in  1  ADC sample valid
- s_axis_tready  out  1  ready; registered as ~rst
- s_axis_dds_tdata  in  32  DDS sample: cos [DDS_W-1:0], sin [DDS_W+15:16]
- s_axis_dds_tvalid  in  1  DDS sample valid
- dec_len  in  DEC_W  samples per output; 0 is treated as 1
- conj_en  in  1  1 = negate sin terms (opposite sideband)
- resync  in  1  pulse: flush pipeline and restart decimation frame
- m_axis_ddc_tdata  out  2*OUT_W  I [OUT_W-1:0], Q [2*OUT_W-1:OUT_W], sign-extended
- m_axis_ddc_tvalid  out  1  one-cycle pulse per decimated result
- m_axis_ddc_tlast  out  1  high with tvalid on the first output after reset/resync

Behaviour:
- Reset values: s_axis_tready=0, m_axis_ddc_tvalid=0, tlast=0, tdata=0. Accumulators, counter and valid pipeline are cleared. Reset is honoured mid-frame; the partial sum is discarded.
- Accepted sample = s_axis_tvalid & s_axis_dds_tvalid & s_axis_tready. Other cycles insert a bubble; nothing is counted.
- Mixer equations, with s = sin when conj_en=0 and -sin when conj_en=1:
  - I = dI*cos + dQ*s
  - Q = dQ*cos - dI*s
- Mixer arithmetic:
  - Products are ADC_W+DDS_W bits; sums are MIX_W = ADC_W+DDS_W+1 bits, exact with no saturation.
  - conj_en is sampled alongside the data, so it travels with each sample.
- Mixer latency LAT = MUL_STAGES+1. A valid shift register of length LAT marks mixer outputs.
- Decimator, acting on each mixer-valid cycle:
  - If cnt == len_l-1: emit acc+mix on the next edge with m_axis_ddc_tvalid=1, then set acc<=0, cnt<=0, and len_l <= max(dec_len,1).
  - Otherwise: acc += mix, cnt++.
- len_l is latched only at frame boundaries, reset and resync. Changing dec_len mid-frame never shortens or stretches the current frame.
- Accumulator width is OUT_W, so overflow is impossible by construction.
- End-to-end latency for dec_len=1 is LAT+1 = 7 cycles from accepted input to m_axis_ddc_tvalid.
- resync, at cycle t:
  - Clears the valid pipeline, acc, cnt and output valid at t+1, and reloads len_l.
  - A sample accepted in the same cycle as resync is the first sample of the new frame.
  - The first output after resync carries tlast=1.
- resync together with a frame-completing mixer output: resync wins and no output is produced.
- m_axis_ddc_tvalid is a single-cycle pulse with no backpressure; the downstream FIFO absorbs it. tdata holds its value until the next result.

Decomposition:
- Package ddc_pkg:
  - lane offsets (LANE_W=16)
  - function mix_w(adc_w, dds_w)
  - function min_out_w(adc_w, dds_w, dec_w)
  - default parameter values
- Sub-module cmix_pipe: pipelined complex multiplier with conj control, MUL_STAGES-deep products, registered add/sub, and a valid shift register.
- The top level contains the decimator FSM, counter and output registers.

Test Plan:
- dec_len=1, conj_en=0, dI=100, dQ=0, cos=8191, sin=0, continuous -> I=819100, Q=0, tvalid every cycle, first output 7 cycles after first accept, tlast=1 on the first output only.
- dI=0, dQ=100, cos=0, sin=8191; conj_en=0 then 1 -> I=819100 then I=-819100, Q=0 in both cases; the switch lands exactly on the sample where conj_en toggled.
- dec_len=4, dI=-2048, cos=-8192, sin=0, with s_axis_tvalid low on every third cycle -> I=67108864 (4*16777216) once per 4 accepted samples, no output during bubbles.
- dec_len=4 running; set dec_len=2 after 1 sample of a frame -> current frame still sums 4 samples, subsequent frames sum 2.
- resync asserted after 3 of 8 samples, plus resync coincident with a frame end -> no output for the partial frame, next output after 8 further samples with tlast=1; coincident case emits nothing.
- rst asserted mid-frame for 1 cycle -> all outputs 0 next cycle, tready=0 during rst and 1 the cycle after; dec_len=0 afterwards behaves as 1.

Source files
------------

// File: rtl/ddc_pkg.sv
// ddc_pkg: shared lane layout, width helpers and defaults for the decimating DDC
package ddc_pkg;
  localparam int LANE_W = 16;
  localparam int I_OFF = 0;
  localparam int Q_OFF = LANE_W;
  localparam int ADC_W_DEF = 12;
  localparam int DDS_W_DEF = 14;
  localparam int MUL_STAGES_DEF = 5;
  localparam int DEC_W_DEF = 16;
  localparam int OUT_W_DEF = 48;
  typedef enum logic {ST_FIRST, ST_RUN} dec_st_e;
  function automatic int mix_w(int adc_w, int dds_w);
    return adc_w + dds_w + 1;
  endfunction
  function automatic int min_out_w(int adc_w, int dds_w, int dec_w);
    return mix_w(adc_w, dds_w) + dec_w;
  endfunction
endpackage

// File: rtl/ddc_dec_core_cmix_pipe.sv
// cmix_pipe: pipelined complex multiplier with per-sample conjugate control
module cmix_pipe
  import ddc_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int DDS_W = DDS_W_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int MIX_W = mix_w(ADC_W, DDS_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [ADC_W-1:0]        d_i,
  input  logic [ADC_W-1:0]        d_q,
  input  logic [DDS_W-1:0]        cos_v,
  input  logic [DDS_W-1:0]        sin_v,
  input  logic                    conj,
  output logic                    out_valid,
  output logic signed [MIX_W-1:0] mix_i,
  output logic signed [MIX_W-1:0] mix_q
);
  localparam int P_W = ADC_W + DDS_W;
  localparam int LAT = MUL_STAGES + 1;
  logic signed [ADC_W-1:0] ri, rq;
  logic signed [DDS_W-1:0] rc, rs;
  logic rv, rcj;
  logic signed [P_W-1:0] p_ic [MUL_STAGES];
  logic signed [P_W-1:0] p_qs [MUL_STAGES];
  logic signed [P_W-1:0] p_qc [MUL_STAGES];
  logic signed [P_W-1:0] p_is [MUL_STAGES];
  logic [MUL_STAGES-1:0] cj;
  logic [LAT-1:0] vld;
  logic signed [MIX_W-1:0] ic, qs, qc, is_x;
  assign ic = MIX_W'(p_ic[MUL_STAGES-1]);
  assign qs = MIX_W'(p_qs[MUL_STAGES-1]);
  assign qc = MIX_W'(p_qc[MUL_STAGES-1]);
  assign is_x = MIX_W'(p_is[MUL_STAGES-1]);
  assign out_valid = vld[LAT-1];
  // Negating the products rather than sin keeps the most-negative sin exact
  always_ff @(posedge clk) begin
    ri <= d_i;
    rq <= d_q;
    rc <= cos_v;
    rs <= sin_v;
    rcj <= conj;
    p_ic[0] <= P_W'(ri) * P_W'(rc);
    p_qs[0] <= P_W'(rq) * P_W'(rs);
    p_qc[0] <= P_W'(rq) * P_W'(rc);
    p_is[0] <= P_W'(ri) * P_W'(rs);
    cj[0] <= rcj;
    for (int k = 1; k < MUL_STAGES; k++) begin
      p_ic[k] <= p_ic[k-1];
      p_qs[k] <= p_qs[k-1];
      p_qc[k] <= p_qc[k-1];
      p_is[k] <= p_is[k-1];
      cj[k] <= cj[k-1];
    end
    mix_i <= cj[MUL_STAGES-1] ? ic - qs : ic + qs;
    mix_q <= cj[MUL_STAGES-1] ? qc + is_x : qc - is_x;
  end
  // A sample accepted alongside flush survives; everything older is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      rv <= 1'b0;
      vld <= '0;
    end else begin
      rv <= in_valid;
      vld <= flush ? '0 : {vld[LAT-2:0], rv};
    end
  end
endmodule

// File: rtl/ddc_dec_core.sv
// ddc_dec_core: complex DDS mixer followed by an integrate-and-dump decimator
module ddc_dec_core
  import ddc_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int DDS_W = DDS_W_DEF,
  parameter int MUL_STAGES = MUL_STAGES_DEF,
  parameter int DEC_W = DEC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic               s_axis_aclk,
  input  logic               rst,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [31:0]        s_axis_dds_tdata,
  input  logic               s_axis_dds_tvalid,
  input  logic [DEC_W-1:0]   dec_len,
  input  logic               conj_en,
  input  logic               resync,
  output logic [2*OUT_W-1:0] m_axis_ddc_tdata,
  output logic               m_axis_ddc_tvalid,
  output logic               m_axis_ddc_tlast
);
  localparam int MIX_W = mix_w(ADC_W, DDS_W);
  if (OUT_W < min_out_w(ADC_W, DDS_W, DEC_W)) begin : g_bad_out_w
    $error("ddc_dec_core: OUT_W too small for ADC_W+DDS_W+1+DEC_W");
  end
  logic accept, mix_v, done;
  logic signed [MIX_W-1:0] mix_i, mix_q;
  logic signed [OUT_W-1:0] acc_i, acc_q, sum_i, sum_q;
  logic [DEC_W-1:0] cnt, len_l, len_n;
  dec_st_e state_q, state_d;
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axis_tdata, s_axis_dds_tdata};
  assign accept = s_axis_tvalid & s_axis_dds_tvalid & s_axis_tready;
  cmix_pipe #(
    .ADC_W(ADC_W),
    .DDS_W(DDS_W),
    .MUL_STAGES(MUL_STAGES),
    .MIX_W(MIX_W)
  ) u_cmix (
    .clk(s_axis_aclk),
    .rst(rst),
    .flush(resync),
    .in_valid(accept),
    .d_i(s_axis_tdata[I_OFF +: ADC_W]),
    .d_q(s_axis_tdata[Q_OFF +: ADC_W]),
    .cos_v(s_axis_dds_tdata[I_OFF +: DDS_W]),
    .sin_v(s_axis_dds_tdata[Q_OFF +: DDS_W]),
    .conj(conj_en),
    .out_valid(mix_v),
    .mix_i(mix_i),
    .mix_q(mix_q)
  );
  assign len_n = (dec_len == '0) ? DEC_W'(1) : dec_len;
  assign sum_i = acc_i + OUT_W'(mix_i);
  assign sum_q = acc_q + OUT_W'(mix_q);
  assign done = mix_v & (cnt == len_l - DEC_W'(1));
  always_ff @(posedge s_axis_aclk) begin
    s_axis_tready <= ~rst;
    state_q <= rst ? ST_FIRST : state_d;
  end
  always_comb begin
    state_d = resync ? ST_FIRST : done ? ST_RUN : state_q;
  end
  // len_l reloads only at frame boundaries so a mid-frame dec_len change waits its turn
  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      acc_i <= '0;
      acc_q <= '0;
      cnt <= '0;
      len_l <= len_n;
      m_axis_ddc_tvalid <= 1'b0;
      m_axis_ddc_tlast <= 1'b0;
      m_axis_ddc_tdata <= '0;
    end else begin
      m_axis_ddc_tvalid <= done & ~resync;
      m_axis_ddc_tlast <= done & ~resync & (state_q == ST_FIRST);
      if (done & ~resync) m_axis_ddc_tdata <= {sum_q, sum_i};
      if (resync | done) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt <= '0;
        len_l <= len_n;
      end else if (mix_v) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt <= cnt + DEC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_ddc_dec_core.sv
// tb_ddc_dec_core: scoreboard bench for the mixer/decimator against a behavioural model
module tb_ddc_dec_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] s_axis_tdata = '0, s_axis_dds_tdata = '0;
  logic s_axis_tvalid = 1'b0, s_axis_dds_tvalid = 1'b0, s_axis_tready;
  logic [15:0] dec_len = 16'd1;
  logic conj_en = 1'b0, resync = 1'b0;
  logic [95:0] m_axis_ddc_tdata;
  logic m_axis_ddc_tvalid, m_axis_ddc_tlast;
  always #5 clk = ~clk;
  ddc_dec_core dut (
    .s_axis_aclk(clk),
    .rst(rst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_dds_tdata(s_axis_dds_tdata),
    .s_axis_dds_tvalid(s_axis_dds_tvalid),
    .dec_len(dec_len),
    .conj_en(conj_en),
    .resync(resync),
    .m_axis_ddc_tdata(m_axis_ddc_tdata),
    .m_axis_ddc_tvalid(m_axis_ddc_tvalid),
    .m_axis_ddc_tlast(m_axis_ddc_tlast)
  );
  typedef struct {longint i; longint q; bit last; int e;} exp_t;
  exp_t sb[$];
  exp_t ex;
  int n_chk = 0, n_pass = 0, cyc = 0, cnt = 0, len = 1;
  longint acc_i = 0, acc_q = 0;
  bit first = 1'b1, rdy_m = 1'b0;
  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
  endtask
  // Anything whose output edge is at or after this edge is lost to the flush
  function automatic void flush_m();
    while (sb.size() > 0 && sb[$].e >= cyc - 7) void'(sb.pop_back());
    acc_i = 0;
    acc_q = 0;
    cnt = 0;
    len = (dec_len == 0) ? 1 : int'(dec_len);
    first = 1'b1;
  endfunction
  task automatic step(bit v, bit dv, int di, int dq, int c, int s, bit cj, bit rs, bit r);
    bit a;
    longint si, mi, mq;
    s_axis_tvalid = v;
    s_axis_dds_tvalid = dv;
    s_axis_tdata = {16'(dq), 16'(di)};
    s_axis_dds_tdata = {16'(s), 16'(c)};
    conj_en = cj;
    resync = rs;
    rst = r;
    @(posedge clk);
    cyc++;
    a = v & dv & rdy_m;
    rdy_m = !r;
    if (r) flush_m();
    else begin
      if (rs) flush_m();
      if (a) begin
        si = cj ? -longint'(s) : longint'(s);
        mi = longint'(di) * c + longint'(dq) * si;
        mq = longint'(dq) * c - longint'(di) * si;
        acc_i += mi;
        acc_q += mq;
        if (cnt == len - 1) begin
          sb.push_back('{acc_i, acc_q, first, cyc});
          first = 1'b0;
          acc_i = 0;
          acc_q = 0;
          cnt = 0;
          len = (dec_len == 0) ? 1 : int'(dec_len);
        end else cnt++;
      end
    end
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    chk("tready", s_axis_tready, rdy_m);
    if (m_axis_ddc_tvalid) begin
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        ex = sb.pop_front();
        chk("out_I", $signed(m_axis_ddc_tdata[47:0]), ex.i);
        chk("out_Q", $signed(m_axis_ddc_tdata[95:48]), ex.q);
        chk("tlast", m_axis_ddc_tlast, ex.last);
        chk("latency", cyc - ex.e, 7);
      end
    end else chk("tlast_idle", m_axis_ddc_tlast, 0);
  end
  initial begin
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_tvalid", m_axis_ddc_tvalid, 0);
    chk("rst_tlast", m_axis_ddc_tlast, 0);
    chk("rst_tdata", longint'(m_axis_ddc_tdata != 0), 0);
    idle(2);
    repeat (10) step(1, 1, 100, 0, 8191, 0, 0, 0, 0);
    idle(10);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 100, 0, 8191, i[0], 0, 0);
    idle(10);
    dec_len = 16'd4;
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 24; i++) step(i % 3 != 2, i != 10, -2048, 0, -8192, 0, 0, 0, 0);
    idle(10);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 50, -30, 1000, -700, 0, 0, 0);
    dec_len = 16'd2;
    for (int i = 0; i < 13; i++) step(1, 1, 10 * i - 60, 7 * i, 4000 - 300 * i, -2000 + 500 * i, i[1], 0, 0);
    idle(10);
    dec_len = 16'd8;
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 300, -200, 5000, 3000, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 11 * i, -5 * i, 2000 + i, -1000, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, -7 * i, 3 * i, 1500, 900 - i, 1, 0, 0);
    idle(6);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(10);
    dec_len = 16'd2;
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 40, 20, 300, 100, 0, 0, 0);
    step(1, 1, 400, 200, 3000, 1000, 0, 1, 0);
    step(1, 1, -40, 60, 700, -500, 0, 0, 0);
    idle(10);
    dec_len = 16'd4;
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) step(1, 1, 123, 45, 6000, -6000, 0, 0, 0);
    dec_len = 16'd0;
    step(1, 1, 123, 45, 6000, -6000, 0, 0, 1);
    chk("rst_mid_tvalid", m_axis_ddc_tvalid, 0);
    chk("rst_mid_tlast", m_axis_ddc_tlast, 0);
    chk("rst_mid_tdata", longint'(m_axis_ddc_tdata != 0), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 20 + i, -9, 8000, 4000 - i, 0, 0, 0);
    idle(12);
    chk("drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
